// File: rtl/icache_response_stage_if.sv
// Bundle between the allocate stage, the response stage, fetch and the cache arrays.
// The response stage uses the slave view; whatever drives it uses the master view.
interface icache_response_stage_if #(
  parameter int SETS = 16
);
  localparam int S = $clog2(SETS);
  localparam int T = 27 - S;

  logic         read_stall;
  logic         alloc_valid;
  logic         alloc_cache_hit;
  logic [1:0]   alloc_hit_way;
  logic [255:0] alloc_rdata;
  logic [4:0]   alloc_offset;
  logic [S-1:0] alloc_set;
  logic [T-1:0] alloc_tag;
  logic         flush;
  logic         fetch_ready;

  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic [31:0]  resp_addr;
  logic         stage_stall;
  logic         arr_we;
  logic [1:0]   arr_way;
  logic [S-1:0] arr_set;
  logic [T-1:0] arr_tag;
  logic [255:0] arr_wdata;
  logic         fwd_valid;
  logic [T-1:0] fwd_tag;
  logic [S-1:0] fwd_set;
  logic [255:0] fwd_line;

  modport slave (
    input  read_stall, alloc_valid, alloc_cache_hit, alloc_hit_way, alloc_rdata,
           alloc_offset, alloc_set, alloc_tag, flush, fetch_ready,
    output resp_valid, resp_rdata, resp_addr, stage_stall, arr_we, arr_way, arr_set,
           arr_tag, arr_wdata, fwd_valid, fwd_tag, fwd_set, fwd_line
  );

  modport master (
    output read_stall, alloc_valid, alloc_cache_hit, alloc_hit_way, alloc_rdata,
           alloc_offset, alloc_set, alloc_tag, flush, fetch_ready,
    input  resp_valid, resp_rdata, resp_addr, stage_stall, arr_we, arr_way, arr_set,
           arr_tag, arr_wdata, fwd_valid, fwd_tag, fwd_set, fwd_line
  );
endinterface

// File: rtl/icache_response_stage.sv
// Last icache pipeline stage: registers the allocated line, returns the fetch word,
// writes missed lines into the arrays and keeps per-set tree-PLRU plus a forward line.
module icache_response_stage #(
  parameter int SETS = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  icache_response_stage_if.slave bus
);
  localparam int S = $clog2(SETS);
  localparam int T = 27 - S;

  logic         valid_q;
  logic         killed_q;
  logic         fill_q;
  logic [1:0]   way_q;
  logic [255:0] rdata_q;
  logic [2:0]   word_q;
  logic [S-1:0] set_q;
  logic [T-1:0] tag_q;
  logic         fwd_valid_q;
  logic [T-1:0] fwd_tag_q;
  logic [S-1:0] fwd_set_q;
  logic [255:0] fwd_line_q;
  logic [2:0]   plru_q [SETS];

  logic         resp_valid;
  logic         stall;
  logic         load;
  logic         bubble;
  logic         fill_d;
  logic [2:0]   plru_cur;
  logic [2:0]   plru_d;
  logic [1:0]   victim;
  logic [1:0]   access_way;
  logic [1:0]   unused_offset;

  assign resp_valid    = valid_q && !killed_q;
  assign stall         = resp_valid && !bus.fetch_ready;
  assign load          = !bus.read_stall && !stall;
  assign bubble        = bus.read_stall && !stall;
  assign fill_d        = load && bus.alloc_valid && !bus.alloc_cache_hit;
  assign unused_offset = bus.alloc_offset[1:0];
  assign plru_cur      = plru_q[bus.alloc_set];

  // Victim selection and PLRU touch; a miss touches the way it is about to fill.
  always_comb begin
    victim     = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
    access_way = bus.alloc_cache_hit ? bus.alloc_hit_way : victim;
    plru_d     = plru_cur;
    case (access_way)
      2'd0: begin plru_d[0] = 1'b1; plru_d[1] = 1'b1; end
      2'd1: begin plru_d[0] = 1'b1; plru_d[1] = 1'b0; end
      2'd2: begin plru_d[0] = 1'b0; plru_d[2] = 1'b1; end
      default: begin plru_d[0] = 1'b0; plru_d[2] = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      killed_q    <= 1'b0;
      fill_q      <= 1'b0;
      way_q       <= '0;
      rdata_q     <= '0;
      word_q      <= '0;
      set_q       <= '0;
      tag_q       <= '0;
      fwd_valid_q <= 1'b0;
      fwd_tag_q   <= '0;
      fwd_set_q   <= '0;
      fwd_line_q  <= '0;
    end else begin
      fill_q <= fill_d;
      if (load) begin
        valid_q  <= bus.alloc_valid;
        killed_q <= 1'b0;
        way_q    <= access_way;
        rdata_q  <= bus.alloc_rdata;
        word_q   <= bus.alloc_offset[4:2];
        set_q    <= bus.alloc_set;
        tag_q    <= bus.alloc_tag;
      end else if (bubble) begin
        valid_q  <= 1'b0;
        killed_q <= 1'b0;
      end else if (bus.flush && valid_q) begin
        killed_q <= 1'b1;
      end
      // Forward copy becomes visible together with the array write it shadows.
      if (fill_d) begin
        fwd_valid_q <= 1'b1;
        fwd_tag_q   <= bus.alloc_tag;
        fwd_set_q   <= bus.alloc_set;
        fwd_line_q  <= bus.alloc_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) plru_q[i] <= '0;
    end else if (load && bus.alloc_valid) begin
      plru_q[bus.alloc_set] <= plru_d;
    end
  end

  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = rdata_q[{word_q, 5'b00000} +: 32];
  assign bus.resp_addr   = {tag_q, set_q, word_q, 2'b00};
  assign bus.stage_stall = stall;
  assign bus.arr_we      = fill_q;
  assign bus.arr_way     = way_q;
  assign bus.arr_set     = set_q;
  assign bus.arr_tag     = tag_q;
  assign bus.arr_wdata   = rdata_q;
  assign bus.fwd_valid   = fwd_valid_q;
  assign bus.fwd_tag     = fwd_tag_q;
  assign bus.fwd_set     = fwd_set_q;
  assign bus.fwd_line    = fwd_line_q;
endmodule

// File: tb/tb_icache_response_stage.sv
// Bench for icache_response_stage: directed scenarios with literal expectations, then
// random traffic compared every cycle against a recency-based behavioural model.
module tb_icache_response_stage;
  localparam int SETS = 16;
  localparam int S = 4;
  localparam int T = 23;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_response_stage_if #(.SETS(SETS)) bus ();
  icache_response_stage #(.SETS(SETS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  bit running = 0;

  bit           mValid, mKilled, mFill, mFwdValid;
  bit [255:0]   mLine, mFillLine, mFwdLine;
  bit [4:0]     mOff;
  bit [S-1:0]   mSet, mFillSet, mFwdSet;
  bit [T-1:0]   mTag, mFillTag, mFwdTag;
  bit [1:0]     mFillWay;
  int           lastHalf [SETS];
  int           lastInPair [SETS][2];
  bit           expResp;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Tree PLRU viewed as "which half was used last, and which way in each pair".
  function automatic int victimOf(int s);
    if (lastHalf[s] == 1) return (lastInPair[s][0] == 0) ? 1 : 0;
    return (lastInPair[s][1] == 2) ? 3 : 2;
  endfunction

  task automatic resetModel();
    mValid = 0; mKilled = 0; mFill = 0; mFwdValid = 0;
    mLine = '0; mOff = '0; mSet = '0; mTag = '0;
    mFillLine = '0; mFillSet = '0; mFillTag = '0; mFillWay = '0;
    mFwdLine = '0; mFwdSet = '0; mFwdTag = '0;
    for (int s = 0; s < SETS; s++) begin
      lastHalf[s] = 1;
      lastInPair[s][0] = 1;
      lastInPair[s][1] = 3;
    end
  endtask

  task automatic modelUpdate();
    bit stallNow;
    int w;
    int s;
    if (!rst_n) return;
    stallNow = mValid && !mKilled && !bus.fetch_ready;
    mFill = 0;
    if (!bus.read_stall && !stallNow) begin
      if (bus.alloc_valid) begin
        s = int'(bus.alloc_set);
        w = bus.alloc_cache_hit ? int'(bus.alloc_hit_way) : victimOf(s);
        lastHalf[s] = w / 2;
        lastInPair[s][w / 2] = w;
        if (!bus.alloc_cache_hit) begin
          mFill = 1; mFillWay = 2'(w);
          mFillSet = bus.alloc_set; mFillTag = bus.alloc_tag; mFillLine = bus.alloc_rdata;
          mFwdValid = 1;
          mFwdSet = bus.alloc_set; mFwdTag = bus.alloc_tag; mFwdLine = bus.alloc_rdata;
        end
      end
      mValid = bus.alloc_valid; mKilled = 0;
      mLine = bus.alloc_rdata; mOff = bus.alloc_offset;
      mSet = bus.alloc_set; mTag = bus.alloc_tag;
    end else if (!stallNow) begin
      mValid = 0; mKilled = 0;
    end else if (bus.flush) begin
      mKilled = 1;
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      expResp = mValid && !mKilled;
      checkOutput("resp_valid", 256'(bus.resp_valid), 256'(expResp));
      checkOutput("stage_stall", 256'(bus.stage_stall), 256'(expResp && !bus.fetch_ready));
      if (expResp) begin
        checkOutput("resp_rdata", 256'(bus.resp_rdata), 256'(32'(mLine >> (32 * int'(mOff[4:2])))));
        checkOutput("resp_addr", 256'(bus.resp_addr),
                    256'((32'(mTag) << 9) | (32'(mSet) << 5) | 32'(mOff & 5'h1C)));
      end
      checkOutput("arr_we", 256'(bus.arr_we), 256'(mFill));
      if (mFill) begin
        checkOutput("arr_way", 256'(bus.arr_way), 256'(mFillWay));
        checkOutput("arr_set", 256'(bus.arr_set), 256'(mFillSet));
        checkOutput("arr_tag", 256'(bus.arr_tag), 256'(mFillTag));
        checkOutput("arr_wdata", bus.arr_wdata, mFillLine);
      end
      checkOutput("fwd_valid", 256'(bus.fwd_valid), 256'(mFwdValid));
      if (mFwdValid) begin
        checkOutput("fwd_tag", 256'(bus.fwd_tag), 256'(mFwdTag));
        checkOutput("fwd_set", 256'(bus.fwd_set), 256'(mFwdSet));
        checkOutput("fwd_line", bus.fwd_line, mFwdLine);
      end
    end
  end

  task automatic applyStimulus(input bit v, input bit h, input bit [1:0] hw, input logic [255:0] ln,
                               input bit [4:0] off, input bit [S-1:0] st, input bit [T-1:0] tg,
                               input bit rs, input bit fl, input bit fr);
    bus.alloc_valid = v; bus.alloc_cache_hit = h; bus.alloc_hit_way = hw;
    bus.alloc_rdata = ln; bus.alloc_offset = off; bus.alloc_set = st; bus.alloc_tag = tg;
    bus.read_stall = rs; bus.flush = fl; bus.fetch_ready = fr;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 2'd0, '0, 5'd0, '0, '0, 0, 0, 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  function automatic logic [255:0] mkLine(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_resp_valid"}, 256'(bus.resp_valid), 256'(0));
    checkOutput({tag, "_resp_rdata"}, 256'(bus.resp_rdata), 256'(0));
    checkOutput({tag, "_resp_addr"}, 256'(bus.resp_addr), 256'(0));
    checkOutput({tag, "_stage_stall"}, 256'(bus.stage_stall), 256'(0));
    checkOutput({tag, "_arr_we"}, 256'(bus.arr_we), 256'(0));
    checkOutput({tag, "_arr_way"}, 256'(bus.arr_way), 256'(0));
    checkOutput({tag, "_arr_wdata"}, bus.arr_wdata, 256'(0));
    checkOutput({tag, "_fwd_valid"}, 256'(bus.fwd_valid), 256'(0));
    checkOutput({tag, "_fwd_line"}, bus.fwd_line, 256'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] ln;
    int expWay [4];
    int weCount;
    expWay = '{0, 2, 1, 3};

    idle();
    rst_n = 1'b0;
    resetModel();
    running = 1;
    #2;
    checkAllZero("reset");
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Hit way0 in set 5, word 5.
    ln = mkLine(32'h1000_0000);
    ln[160 +: 32] = 32'hDEADBEEF;
    applyStimulus(1, 1, 2'd0, ln, 5'h14, 4'd5, 23'h1, 0, 0, 1);
    cycle();
    idle();
    #1;
    checkOutput("hit_resp_valid", 256'(bus.resp_valid), 256'(1));
    checkOutput("hit_resp_rdata", 256'(bus.resp_rdata), 256'(32'hDEADBEEF));
    checkOutput("hit_resp_addr", 256'(bus.resp_addr), 256'(32'h0000_02B4));
    checkOutput("hit_arr_we", 256'(bus.arr_we), 256'(0));
    applyStimulus(1, 0, 2'd0, mkLine(32'h2000_0000), 5'h0, 4'd5, 23'h2, 0, 0, 1);
    cycle();
    checkOutput("set5_miss1_way", 256'(bus.arr_way), 256'(2));
    applyStimulus(1, 0, 2'd0, mkLine(32'h2100_0000), 5'h0, 4'd5, 23'h3, 0, 0, 1);
    cycle();
    checkOutput("set5_miss2_way", 256'(bus.arr_way), 256'(1));
    idle();
    cycle();

    // Four misses to set 2 from reset state.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'd0, mkLine(32'h3000_0000 + 32'(i << 8)), 5'h4, 4'd2, 23'(100 + i), 0, 0, 1);
      cycle();
      checkOutput("set2_arr_we", 256'(bus.arr_we), 256'(1));
      checkOutput("set2_arr_way", 256'(bus.arr_way), 256'(expWay[i]));
      checkOutput("set2_fwd_tag", 256'(bus.fwd_tag), 256'(100 + i));
    end
    idle();
    cycle();

    // Back-pressure for three cycles on a miss.
    applyStimulus(1, 0, 2'd0, mkLine(32'hA000_0000), 5'h0B, 4'd7, 23'h12345, 0, 0, 1);
    cycle();
    applyStimulus(1, 1, 2'd1, mkLine(32'hB000_0000), 5'h0, 4'd8, 23'h7, 0, 0, 0);
    weCount = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_stage_stall", 256'(bus.stage_stall), 256'(1));
      checkOutput("bp_resp_addr", 256'(bus.resp_addr), 256'(32'h0246_8AE8));
      checkOutput("bp_resp_rdata", 256'(bus.resp_rdata), 256'(32'hA000_0002));
      weCount += int'(bus.arr_we);
      cycle();
    end
    checkOutput("bp_arr_we_count", 256'(weCount), 256'(1));
    bus.fetch_ready = 1'b1;
    #1;
    checkOutput("bp_released", 256'(bus.stage_stall), 256'(0));
    cycle();
    idle();
    cycle();

    // Flush on a resident miss.
    applyStimulus(1, 0, 2'd0, mkLine(32'hC0C0_0000), 5'h8, 4'd9, 23'h00ABC, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 2'd0, '0, 5'h0, 4'd0, 23'h0, 0, 1, 0);
    #1;
    checkOutput("fl_arr_we", 256'(bus.arr_we), 256'(1));
    checkOutput("fl_arr_set", 256'(bus.arr_set), 256'(9));
    checkOutput("fl_arr_tag", 256'(bus.arr_tag), 256'(23'h00ABC));
    checkOutput("fl_arr_wdata", bus.arr_wdata, mkLine(32'hC0C0_0000));
    cycle();
    bus.flush = 1'b0;
    #1;
    checkOutput("fl_resp_valid", 256'(bus.resp_valid), 256'(0));
    checkOutput("fl_arr_we_after", 256'(bus.arr_we), 256'(0));
    bus.fetch_ready = 1'b1;
    cycle();

    // read_stall bubbles leave PLRU of set 11 untouched.
    applyStimulus(1, 0, 2'd0, mkLine(32'hD000_0000), 5'h0, 4'd11, 23'h55, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checkOutput("rs_resp_valid", 256'(bus.resp_valid), 256'(0));
    end
    bus.read_stall = 1'b0;
    cycle();
    checkOutput("rs_arr_way", 256'(bus.arr_way), 256'(0));
    checkOutput("rs_arr_we", 256'(bus.arr_we), 256'(1));

    // Random traffic over a few sets so victims collide.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 8; k++) ln[k*32 +: 32] = $urandom();
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), ln,
                    5'($urandom_range(0, 31)), 4'($urandom_range(0, 3)), 23'($urandom()),
                    $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 7);
      cycle();
    end

    // Reset while a fill is pending.
    applyStimulus(1, 0, 2'd0, mkLine(32'hE000_0000), 5'h0, 4'd6, 23'h66, 0, 0, 1);
    cycle();
    idle();
    #1;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAllZero("midrst");
    cycle(); cycle();
    rst_n = 1'b1;
    applyStimulus(1, 0, 2'd0, mkLine(32'hF000_0000), 5'h0, 4'd3, 23'h33, 0, 0, 1);
    cycle();
    checkOutput("post_rst_arr_we", 256'(bus.arr_we), 256'(1));
    checkOutput("post_rst_arr_way", 256'(bus.arr_way), 256'(0));
    checkOutput("post_rst_arr_set", 256'(bus.arr_set), 256'(3));
    idle();
    cycle(); cycle();

    running = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
